// File: rtl/psum_outbuf.sv
`default_nettype none
// ============================================================================
// Module   : psum_outbuf
// Brief    : FWFT circular buffer for finished psums, with tile-completion pulse
// Revision : 1.0
// ============================================================================
module psum_outbuf #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 8,
  parameter int TILE_WORDS = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       outbuf_write,
  input  logic [DATA_W-1:0]          outbuf_wdata,
  output logic                       outbuf_full,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       tile_done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TILE_WORDS + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wp_q, wp_d;
  logic [AW-1:0]     rp_q, rp_d;
  logic [CW-1:0]     count_q, count_d;
  logic [TW-1:0]     tc_q, tc_d;
  logic              overflow_q, overflow_d;
  logic              tile_done_q, tile_done_d;
  logic              wr_acc, rd_acc;

  // Full is decoded from the registered count only, so a same-cycle read
  // never opens a slot for a same-cycle write.
  assign outbuf_full = (count_q == CW'(DEPTH));
  assign out_valid   = (count_q != '0);
  assign out_data    = out_valid ? mem_q[rp_q] : '0;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign tile_done   = tile_done_q;

  assign wr_acc = outbuf_write & ~outbuf_full;
  assign rd_acc = out_valid & out_ready;

  always_comb begin
    wp_d        = wp_q;
    rp_d        = rp_q;
    count_d     = count_q;
    tc_d        = tc_q;
    overflow_d  = overflow_q;
    tile_done_d = 1'b0;

    if (wr_acc) begin
      wp_d = wp_q + AW'(1);
    end
    if (outbuf_write && outbuf_full) begin
      overflow_d = 1'b1;
    end
    if (rd_acc) begin
      rp_d = rp_q + AW'(1);
      if (tc_q == TW'(TILE_WORDS - 1)) begin
        tc_d        = '0;
        tile_done_d = 1'b1;
      end else begin
        tc_d = tc_q + TW'(1);
      end
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      tc_q        <= '0;
      overflow_q  <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      tc_q        <= tc_d;
      overflow_q  <= overflow_d;
      tile_done_q <= tile_done_d;
    end
  end

  // Storage is deliberately unreset; stale entries are masked by out_valid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wp_q] <= outbuf_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psum_outbuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_psum_outbuf
// Brief    : Scoreboard bench for psum_outbuf (DEPTH=8, TILE_WORDS=16)
// Revision : 1.0
// ============================================================================
module tb_psum_outbuf;

  localparam int DATA_W     = 16;
  localparam int DEPTH      = 8;
  localparam int TILE_WORDS = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              outbuf_write = 1'b0;
  logic [DATA_W-1:0] outbuf_wdata = '0;
  logic              outbuf_full;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic [3:0]        count;
  logic              overflow;
  logic              tile_done;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] sb[$];
  int   reads   = 0;
  int   td_seen = 0;
  logic exp_td  = 1'b0;

  psum_outbuf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TILE_WORDS(TILE_WORDS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .outbuf_write (outbuf_write),
    .outbuf_wdata (outbuf_wdata),
    .outbuf_full  (outbuf_full),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .count        (count),
    .overflow     (overflow),
    .tile_done    (tile_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_data"}, 32'(out_data), 32'd0);
    chk({name, "_full"}, 32'(outbuf_full), 32'd0);
    chk({name, "_count"}, 32'(count), 32'd0);
    chk({name, "_ovf"}, 32'(overflow), 32'd0);
    chk({name, "_td"}, 32'(tile_done), 32'd0);
  endtask

  // Monitor: samples at the falling edge, pops on every handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("tile_done", 32'(tile_done), 32'(exp_td));
      if (tile_done) td_seen++;
      exp_td = 1'b0;
      if (!out_valid) chk("idle_data_zero", 32'(out_data), 32'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_read", 32'(out_data), 32'hDEAD);
        end else begin
          chk("read_data", 32'(out_data), 32'(sb.pop_front()));
        end
        reads++;
        if (reads % TILE_WORDS == 0) exp_td = 1'b1;
      end
    end
  end

  always @(negedge rst_n) begin
    reads   = 0;
    td_seen = 0;
    exp_td  = 1'b0;
  end

  task automatic wr(input logic [DATA_W-1:0] d, input bit accept);
    outbuf_write = 1'b1;
    outbuf_wdata = d;
    if (accept) sb.push_back(d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int w;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      outbuf_write = 1'($urandom);
      outbuf_wdata = DATA_W'($urandom);
      out_ready    = 1'($urandom);
      tick();
      chk_idle("in_reset");
    end
    outbuf_write = 1'b0;
    out_ready    = 1'b0;
    rst_n        = 1'b1;
    tick();
    chk_idle("after_reset");

    // First word falls through after one cycle
    wr(16'h0011, 1'b1);
    tick();
    outbuf_write = 1'b0;
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_data", 32'(out_data), 32'h11);
    chk("first_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("first_drained", 32'(count), 32'd0);

    // Fill to full, then overflow
    for (int i = 1; i <= DEPTH; i++) begin
      wr(DATA_W'(i), 1'b1);
      tick();
    end
    outbuf_write = 1'b0;
    chk("full_flag", 32'(outbuf_full), 32'd1);
    chk("full_count", 32'(count), 32'd8);
    chk("no_ovf_yet", 32'(overflow), 32'd0);
    wr(16'h0009, 1'b0);
    tick();
    outbuf_write = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);

    // Full with simultaneous read and write: only the read happens
    out_ready = 1'b1;
    wr(16'h00AA, 1'b0);
    tick();
    outbuf_write = 1'b0;
    chk("rw_full_count", 32'(count), 32'd7);
    chk("rw_full_flag", 32'(outbuf_full), 32'd0);
    chk("rw_full_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 7; i++) tick();
    out_ready = 1'b0;
    chk("fill_drained", 32'(count), 32'd0);
    chk("fill_sb_empty", 32'(sb.size()), 32'd0);

    // Wrap-around streaming
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr(DATA_W'(i), 1'b1);
      tick();
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_valid", 32'(out_valid), 32'd1);
    end
    outbuf_write = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("stream_drained", 32'(count), 32'd0);
    chk("stream_sb_empty", 32'(sb.size()), 32'd0);

    // Tile flag with random back-pressure
    do_reset();
    chk_idle("tile_start");
    w = 0;
    n = 0;
    while (w < 40 && n < 400) begin
      out_ready = 1'($urandom);
      if (outbuf_full) begin
        outbuf_write = 1'b0;
      end else begin
        wr(DATA_W'(100 + w), 1'b1);
        w++;
      end
      tick();
      n++;
    end
    outbuf_write = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      out_ready = 1'($urandom);
      tick();
      n++;
    end
    out_ready = 1'b0;
    chk("tile_drain_timeout", 32'(sb.size()), 32'd0);
    tick();
    tick();
    chk("tile_pulses_40", 32'(td_seen), 32'd2);
    // Eight more reads close the third tile only if tc was left at 8
    for (int i = 0; i < 8; i++) begin
      wr(DATA_W'(16'h0200 + i), 1'b1);
      tick();
    end
    outbuf_write = 1'b0;
    chk("tile_pre_count", 32'(td_seen), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    out_ready = 1'b0;
    tick();
    tick();
    chk("tile_pulses_48", 32'(td_seen), 32'd3);

    // Reset mid-operation with count=5 and overflow=1
    for (int i = 0; i < DEPTH; i++) begin
      wr(DATA_W'(16'h0300 + i), 1'b1);
      tick();
    end
    wr(16'h0399, 1'b0);
    tick();
    outbuf_write = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    out_ready = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd5);
    chk("pre_rst_ovf", 32'(overflow), 32'd1);
    rst_n = 1'b0;
    #2;
    sb.delete();
    chk("async_count", 32'(count), 32'd0);
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_ovf", 32'(overflow), 32'd0);
    chk("async_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr(16'h0042, 1'b1);
    tick();
    outbuf_write = 1'b0;
    chk("post_rst_data", 32'(out_data), 32'h42);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);
    chk("post_rst_count", 32'(count), 32'd0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
